// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and control for a same-clock switch port FIFO.
// Produces the RAM read strobe/address, the read-data-valid pipe and registered status flags.
module fifo_read_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  wclk,
    input  logic                  reset,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_occu_out,
    output logic                  underflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

    logic [PW-1:0]         r_rptr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_ren;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [PW-1:0]         r_occu;
    logic                  r_underflow;

    logic          w_empty_fifo;
    logic [PW-1:0] w_occ;
    logic          w_accept;

    // Gating and flags use the pre-edge pointers; a same-edge write is seen next cycle.
    assign w_empty_fifo = (wptr == r_rptr);
    assign w_occ        = wptr - r_rptr;
    assign w_accept     = read_enable && !w_empty_fifo;

    always_ff @(posedge wclk) begin
        if (reset) begin
            r_rptr         <= '0;
            r_raddr        <= '0;
            r_ren          <= 1'b0;
            r_vpipe        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_occu         <= '0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_raddr <= r_rptr[ADDR_WIDTH-1:0];
                r_ren   <= 1'b1;
                r_rptr  <= r_rptr + PW'(1);
            end else begin
                r_ren <= 1'b0;
            end
            r_vpipe[0] <= r_ren;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_empty        <= w_empty_fifo;
            r_almost_empty <= (w_occ <= AeThresh);
            r_occu         <= w_occ;
            r_underflow    <= r_underflow | (read_enable && w_empty_fifo);
        end
    end

    assign rptr          = r_rptr;
    assign raddr         = r_raddr;
    assign ren           = r_ren;
    assign rvalid        = r_vpipe[RD_LATENCY-1];
    assign empty         = r_empty;
    assign almost_empty  = r_almost_empty;
    assign fifo_occu_out = r_occu;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl (ADDR_WIDTH=5, RD_LATENCY=2, AE_THRESH=2).
module tb_fifo_read_ctrl;

    logic       wclk = 1'b0;
    logic       reset;
    logic       read_enable;
    logic [5:0] wptr;
    logic [5:0] rptr;
    logic [4:0] raddr;
    logic       ren;
    logic       rvalid;
    logic       empty;
    logic       almost_empty;
    logic [5:0] fifo_occu_out;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_read_ctrl #(
        .ADDR_WIDTH (5),
        .RD_LATENCY (2),
        .AE_THRESH  (2)
    ) dut (
        .wclk          (wclk),
        .reset         (reset),
        .read_enable   (read_enable),
        .wptr          (wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .ren           (ren),
        .rvalid        (rvalid),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .fifo_occu_out (fifo_occu_out),
        .underflow     (underflow)
    );

    always #5 wclk = ~wclk;

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        read_enable = 1'b0;
        wptr        = 6'd0;
        tick();
        tick();
        chk("rst_rptr", 32'(rptr), 0);
        chk("rst_ren", 32'(ren), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_occu", 32'(fifo_occu_out), 0);
        chk("rst_underflow", 32'(underflow), 0);

        // 1: reads while empty
        reset       = 1'b0;
        read_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_underflow", 32'(underflow), 1);
            chk("t1_ren", 32'(ren), 0);
            chk("t1_rptr", 32'(rptr), 0);
            chk("t1_empty", 32'(empty), 1);
        end

        // 2: four-word burst
        wptr = 6'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_ren", 32'(ren), 1);
            chk("t2_raddr", 32'(raddr), 32'(i));
            chk("t2_rptr", 32'(rptr), 32'(i + 1));
            chk("t2_occu", 32'(fifo_occu_out), 32'(4 - i));
            chk("t2_rvalid", 32'(rvalid), (i >= 2) ? 1 : 0);
            chk("t2_ae", 32'(almost_empty), (i >= 2) ? 1 : 0);
            chk("t2_empty", 32'(empty), 0);
        end
        tick();
        chk("t2_ren_end", 32'(ren), 0);
        chk("t2_empty_end", 32'(empty), 1);
        chk("t2_rptr_end", 32'(rptr), 4);
        chk("t2_rvalid3", 32'(rvalid), 1);
        tick();
        chk("t2_rvalid4", 32'(rvalid), 1);
        tick();
        chk("t2_rvalid_off", 32'(rvalid), 0);

        // 3: full FIFO then drain to threshold
        reset       = 1'b1;
        read_enable = 1'b0;
        wptr        = 6'd32;
        tick();
        reset = 1'b0;
        tick();
        chk("t3_occu_full", 32'(fifo_occu_out), 32);
        chk("t3_ae_full", 32'(almost_empty), 0);
        chk("t3_empty_full", 32'(empty), 0);
        read_enable = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        chk("t3_raddr_last", 32'(raddr), 29);
        chk("t3_occu_lag", 32'(fifo_occu_out), 3);
        read_enable = 1'b0;
        tick();
        chk("t3_occu", 32'(fifo_occu_out), 2);
        chk("t3_ae", 32'(almost_empty), 1);
        chk("t3_rptr", 32'(rptr), 30);
        chk("t3_underflow", 32'(underflow), 0);

        // 4: advance to 62, then wrap
        wptr        = 6'd62;
        read_enable = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        read_enable = 1'b0;
        tick();
        chk("t4_rptr62", 32'(rptr), 62);
        chk("t4_empty62", 32'(empty), 1);
        wptr        = 6'd2;
        read_enable = 1'b1;
        tick();
        chk("t4_occu_wrap", 32'(fifo_occu_out), 4);
        chk("t4_raddr0", 32'(raddr), 30);
        chk("t4_rptr0", 32'(rptr), 63);
        tick();
        chk("t4_raddr1", 32'(raddr), 31);
        chk("t4_rptr1", 32'(rptr), 0);
        tick();
        chk("t4_raddr2", 32'(raddr), 0);
        tick();
        chk("t4_raddr3", 32'(raddr), 1);
        chk("t4_rptr3", 32'(rptr), 2);
        read_enable = 1'b0;
        tick();
        chk("t4_empty_after", 32'(empty), 1);
        chk("t4_underflow", 32'(underflow), 0);

        // 5: write and read on the same edge with one word left
        wptr = 6'd3;
        tick();
        chk("t5_occu_pre", 32'(fifo_occu_out), 1);
        wptr        = 6'd4;
        read_enable = 1'b1;
        tick();
        chk("t5_ren", 32'(ren), 1);
        chk("t5_raddr", 32'(raddr), 2);
        chk("t5_rptr", 32'(rptr), 3);
        chk("t5_empty", 32'(empty), 0);
        read_enable = 1'b0;
        tick();
        chk("t5_occu", 32'(fifo_occu_out), 1);
        chk("t5_empty2", 32'(empty), 0);
        chk("t5_underflow", 32'(underflow), 0);

        // 6: reset while reads are in flight
        wptr        = 6'd10;
        read_enable = 1'b1;
        tick();
        tick();
        chk("t6_ren_pre", 32'(ren), 1);
        reset = 1'b1;
        tick();
        chk("t6_rvalid", 32'(rvalid), 0);
        chk("t6_rptr", 32'(rptr), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_underflow", 32'(underflow), 0);
        chk("t6_ren", 32'(ren), 0);
        reset       = 1'b0;
        read_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_rvalid_post", 32'(rvalid), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
